// File: rtl/step_seq_decoder_pkg.sv
// Shared definitions for the step sequencer and its decoder.
// Holds the default index width, the step value taken on reset/clear,
// and the step index type used by the control path.
package step_seq_decoder_pkg;

    localparam int SEL_W_DEF  = 4;
    localparam int STEP_RESET = 0;

    typedef logic [SEL_W_DEF-1:0] step_t;

endpackage : step_seq_decoder_pkg

// File: rtl/step_seq_decoder_onehot_dec.sv
// Combinational binary-to-one-hot decoder, SEL_W -> 2**SEL_W.
// Exactly one output bit is set for any select value.
module onehot_dec #(
    parameter  int SEL_W = 4,
    localparam int N_OUT = 2**SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    output logic [N_OUT-1:0] onehot
);

    // Set the single bit addressed by sel.
    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule : onehot_dec

// File: rtl/step_seq_decoder.sv
// Registered step sequencer with one-hot step strobes.
// Holds a binary step index, advances or loads it, and registers the
// one-hot decode of the same next-state value so step and onehot always agree.
// Optional build macro: SEQ_ERR_EN adds a sticky err output flagging
// load+adv collisions and loads beyond the current limit.
module step_seq_decoder
    import step_seq_decoder_pkg::*;
#(
    parameter  int SEL_W = SEL_W_DEF,
    localparam int N_OUT = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [SEL_W-1:0] sel,
    input  logic             adv,
    input  logic             stall,
    input  logic [SEL_W-1:0] limit,
    output logic [SEL_W-1:0] step,
    output logic [N_OUT-1:0] onehot,
    output logic             wrap
`ifdef SEQ_ERR_EN
    ,
    output logic             err
`endif
);

    localparam logic [SEL_W-1:0] STEP_INIT = SEL_W'(STEP_RESET);

    logic [SEL_W-1:0] step_nxt;
    logic             wrap_nxt;
    logic [N_OUT-1:0] onehot_nxt;

    // Next step and wrap in priority order: rst > clr > load > stall > adv.
    // The wrap test is an explicit compare so limit below the current step
    // (or a loaded value above limit) also returns to step 0.
    always_comb begin
        step_nxt = step;
        wrap_nxt = 1'b0;
        if (rst || clr) begin
            step_nxt = STEP_INIT;
        end else if (load) begin
            step_nxt = sel;
        end else if (adv && !stall) begin
            if (step >= limit) begin
                step_nxt = STEP_INIT;
                wrap_nxt = 1'b1;
            end else begin
                step_nxt = step + SEL_W'(1);
            end
        end
    end

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .sel    (step_nxt),
        .onehot (onehot_nxt)
    );

    // Register step, its decode and the wrap pulse from one next-state value.
    always_ff @(posedge clk) begin
        if (rst) begin
            step   <= STEP_INIT;
            onehot <= N_OUT'(1) << STEP_RESET;
            wrap   <= 1'b0;
        end else begin
            step   <= step_nxt;
            onehot <= onehot_nxt;
            wrap   <= wrap_nxt;
        end
    end

`ifdef SEQ_ERR_EN
    // Sticky error: set on a load that collides with adv or exceeds limit.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err <= 1'b0;
        end else if (load && (adv || (sel > limit))) begin
            err <= 1'b1;
        end
    end
`endif

endmodule : step_seq_decoder

// File: tb/tb_step_seq_decoder.sv
// Self-checking bench for step_seq_decoder: a table of hand-derived vectors,
// directed sequences (limit 5 counting, full range, limit 0) and random
// stimulus, each checked against a behavioural model. A SEL_W=4 and a
// SEL_W=3 instance run side by side. Honours SEQ_ERR_EN if defined.
module tb_step_seq_decoder;
    import step_seq_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst, clr, load, adv, stall;
    logic [3:0]  sel, limit;
    logic [2:0]  sel3, limit3;
    logic [3:0]  step4;
    logic [15:0] onehot4;
    logic        wrap4;
    logic [2:0]  step3;
    logic [7:0]  onehot3;
    logic        wrap3;
`ifdef SEQ_ERR_EN
    logic        err4, err3;
`endif

    int errors = 0;
    int checks = 0;

    int m4_step = 0, m4_wrap = 0, m4_err = 0;
    int m3_step = 0, m3_wrap = 0, m3_err = 0;

    assign sel3   = sel[2:0];
    assign limit3 = limit[2:0];

    always #5 clk = ~clk;

    step_seq_decoder #(.SEL_W(4)) dut4 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .sel(sel), .adv(adv),
        .stall(stall), .limit(limit), .step(step4), .onehot(onehot4), .wrap(wrap4)
`ifdef SEQ_ERR_EN
        , .err(err4)
`endif
    );

    step_seq_decoder #(.SEL_W(3)) dut3 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .sel(sel3), .adv(adv),
        .stall(stall), .limit(limit3), .step(step3), .onehot(onehot3), .wrap(wrap3)
`ifdef SEQ_ERR_EN
        , .err(err3)
`endif
    );

    typedef struct {
        bit       r, c, l;
        bit [3:0] s;
        bit       a, st;
        bit [3:0] lim;
        int       exp_step;
        bit       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference: what the sequencer should hold after one edge.
    task automatic mdl(input int n_out, input int st, input int er,
                       input bit r, input bit c, input bit l, input int s,
                       input bit a, input bit sl, input int lim,
                       output int nst, output int nwr, output int ner);
        nst = st; nwr = 0; ner = er;
        if (r || c) begin
            nst = 0; ner = 0;
        end else if (l) begin
            nst = s;
            if (a || s > lim) ner = 1;
        end else if (a && !sl) begin
            if (st >= lim) begin
                nst = 0; nwr = 1;
            end else begin
                nst = (st + 1) % n_out;
            end
        end
    endtask

    task automatic run_cycle(input bit r, input bit c, input bit l, input bit [3:0] s,
                             input bit a, input bit sl, input bit [3:0] lim);
        int ns, nw, ne;
        rst = r; clr = c; load = l; sel = s; adv = a; stall = sl; limit = lim;
        @(posedge clk);
        mdl(16, m4_step, m4_err, r, c, l, int'(s), a, sl, int'(lim), ns, nw, ne);
        m4_step = ns; m4_wrap = nw; m4_err = ne;
        mdl(8, m3_step, m3_err, r, c, l, int'(s[2:0]), a, sl, int'(lim[2:0]), ns, nw, ne);
        m3_step = ns; m3_wrap = nw; m3_err = ne;
        #1;
        chk("step4",    32'(step4),   32'(m4_step));
        chk("onehot4",  32'(onehot4), 32'(1) << m4_step);
        chk("wrap4",    32'(wrap4),   32'(m4_wrap));
        chk("ones4",    32'($countones(onehot4)), 32'd1);
        chk("step3",    32'(step3),   32'(m3_step));
        chk("onehot3",  32'(onehot3), 32'(1) << m3_step);
        chk("wrap3",    32'(wrap3),   32'(m3_wrap));
        chk("ones3",    32'($countones(onehot3)), 32'd1);
`ifdef SEQ_ERR_EN
        chk("err4",     32'(err4),    32'(m4_err));
        chk("err3",     32'(err3),    32'(m3_err));
`endif
    endtask

    function automatic vec_t mk(bit r, bit c, bit l, bit [3:0] s, bit a, bit st,
                                bit [3:0] lim, int es, bit ew);
        vec_t v;
        v.r = r; v.c = c; v.l = l; v.s = s; v.a = a; v.st = st; v.lim = lim;
        v.exp_step = es; v.exp_wrap = ew;
        return v;
    endfunction

    initial begin
        rst = 1'b1; clr = 1'b0; load = 1'b0; sel = '0; adv = 1'b0; stall = 1'b0; limit = 4'd5;

        //          r  c  l  sel a  st lim  step wrap
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 5,  0, 0));
        vecs.push_back(mk(0, 0, 1, 9, 0, 0, 5,  9, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 5,  0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 5,  1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 5,  2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 5,  2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 5,  2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 5,  2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 5,  3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 5,  4, 0));
        vecs.push_back(mk(0, 1, 1, 7, 1, 0, 5,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 5,  1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 5,  2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 5,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0));
        vecs.push_back(mk(0, 0, 1, 15, 1, 0, 15, 15, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 15, 0, 1));
        vecs.push_back(mk(0, 0, 1, 3, 1, 1, 15, 3, 0));

        // Table vectors: model-checked every cycle, plus hand-derived values.
        for (int i = 0; i < vecs.size(); i++) begin
            run_cycle(vecs[i].r, vecs[i].c, vecs[i].l, vecs[i].s, vecs[i].a, vecs[i].st, vecs[i].lim);
            chk($sformatf("tbl%0d_step", i),   32'(step4),   32'(vecs[i].exp_step));
            chk($sformatf("tbl%0d_onehot", i), 32'(onehot4), 32'(1) << vecs[i].exp_step);
            chk($sformatf("tbl%0d_wrap", i),   32'(wrap4),   32'(vecs[i].exp_wrap));
        end

        // Reset then 20 advances with limit 5: 0..5 then wrap.
        run_cycle(1, 0, 0, 0, 0, 0, 5);
        for (int i = 0; i < 20; i++) begin
            run_cycle(0, 0, 0, 0, 1, 0, 5);
            chk("lim5_seq", 32'(step4), 32'((i + 1) % 6));
            chk("lim5_wrap", 32'(wrap4), 32'(((i + 1) % 6) == 0));
        end

        // Full range: limit 15 (dut3 sees 7), continuous adv.
        run_cycle(1, 0, 0, 0, 0, 0, 15);
        for (int i = 0; i < 40; i++) begin
            run_cycle(0, 0, 0, 0, 1, 0, 15);
            chk("full4_seq", 32'(step4), 32'((i + 1) % 16));
            chk("full3_seq", 32'(step3), 32'((i + 1) % 8));
        end

        // limit 0: every advance wraps, pulse each cycle.
        for (int i = 0; i < 6; i++) begin
            run_cycle(0, 0, 0, 0, 1, 0, 0);
            chk("lim0_wrap", 32'(wrap4), 32'd1);
            chk("lim0_step", 32'(step4), 32'd0);
        end

        // Random stimulus against the model.
        for (int i = 0; i < 2000; i++) begin
            run_cycle($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                      $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
                      4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_step_seq_decoder

// File: doc/step_seq_decoder.md
Name: step_seq_decoder

Overview:
- Parametrised, registered successor to the combinational 4-to-16 one-hot decoder.
- Holds a binary step index and drives its registered one-hot decode, producing the timing/control-step strobes for the multicycle control path.
- Two modes: direct load of a select value, and auto-advance through steps 0..limit with wrap.
- Adds stall, synchronous clear and a wrap pulse.

Parameters:
- SEL_W, 4, width of the select/step index.
- N_OUT, 2**SEL_W, number of one-hot outputs; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- clr  input  1  synchronous return to step 0; no wrap pulse.
- load  input  1  load step from sel.
- sel  input  SEL_W  step value for load.
- adv  input  1  advance one step.
- stall  input  1  freeze step; blocks adv only.
- limit  input  SEL_W  last step before wrap.
- step  output  SEL_W  current step index, registered.
- onehot  output  N_OUT  registered decode; onehot[step] = 1, all other bits 0.
- wrap  output  1  one-cycle pulse on the cycle after an advance from a step >= limit.

Behaviour:
- Everything is updated on the rising edge of clk. Priority per edge: rst > clr > load > stall > adv.
- Reset and clear:
  - rst: step = 0, onehot = 1 (bit 0 only), wrap = 0.
  - clr: same values as rst.
- Load:
  - load: step <= sel; onehot <= 1 << sel; wrap <= 0.
  - Latency 1 cycle from sel to outputs.
  - load overrides both stall and adv.
- Advance:
  - adv & ~stall & step < limit: step <= step + 1; wrap <= 0.
  - adv & ~stall & step >= limit: step <= 0; wrap <= 1 for exactly one cycle.
  - Covers limit changed below the current step, and a loaded sel > limit.
- Stall / idle:
  - stall & ~load, or no command: step and onehot hold; wrap <= 0.
- Boundary cases:
  - limit = 0: every adv leaves step at 0 and pulses wrap.
  - limit = N_OUT-1: full-range counting; the wrap from N_OUT-1 to 0 uses an explicit compare, never reliance on overflow.
  - Back-to-back adv: wrap is high for 1 cycle only, never stretched.
- Invariants:
  - onehot always has exactly one bit set.
  - onehot is always consistent with step in the same cycle; both come from the same next-state value.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SEQ_ERR_EN.
- Defined:
  - Adds output err (1 bit, sticky).
  - err is set on the edge after either: load & adv asserted together, or load with sel > limit.
  - err is cleared only by rst or clr; it does not alter the step behaviour.
- Undefined: no err port, no extra logic.

Decomposition:
- Shared package/include: SEL_W default (4), STEP_RESET value (0), step index typedef for the control path.
- One natural sub-module: onehot_dec, a combinational SEL_W -> 2**SEL_W decoder.
  - Fed the next-state step; its output is registered in step_seq_decoder.
  - Replaces the hand-enumerated decoder style.

Test Plan:
1. Reset, then 20 cycles with adv = 1, limit = 5: step runs 0,1,2,3,4,5,0,...; onehot = 0x0001..0x0020; wrap high in the cycle after each 5 -> 0 advance.
2. load with sel = 9, limit = 5, then adv: step = 9, onehot = 0x0200, then step = 0 and wrap = 1; with SEQ_ERR_EN, err = 1 after the load.
3. adv = 1 with stall pulsed high 3 cycles at step 2: step holds at 2 for 3 cycles, then resumes at 3; wrap = 0 throughout.
4. Simultaneous clr & load (sel = 7) at step 4: step = 0, onehot = 0x0001, wrap = 0; then rst asserted mid-count gives the same values.
5. limit = 15, SEL_W = 4, continuous adv: 15 -> 0 wrap; onehot = 0x8000 then 0x0001. Repeat with SEL_W = 3: N_OUT = 8, 7 -> 0.
6. limit = 0, adv every cycle: step stays 0 and wrap is asserted each cycle. Every scenario asserts $countones(onehot) == 1 and onehot == 1 << step.
